// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle single-port memory between instruction fetch and
// the memory stage, with the stack pointer maintained here for push/pop.
module mem_port_arbiter #(
  parameter int               ADDR_W    = 16,
  parameter int               DATA_W    = 16,
  parameter int               MEM_LAT   = 1,
  parameter logic [ADDR_W-1:0] SP_INIT  = 16'hFFFF,
  parameter int               MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_push,
  input  logic              dm_pop,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sp
);

  localparam int CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              is_if;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t             state_q, state_d;
  cmd_t               cmd_q;
  logic [CNT_W-1:0]   lat_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               burst_full;
  logic               if_win;
  logic               last_beat;
  logic [ADDR_W-1:0]  sp_inc;

  assign burst_full = (burst_cnt == BURST_W'(MAX_BURST));
  // Fetch only beats a pending data request once the data side has used up its burst.
  assign if_win     = if_req && (!dm_req || burst_full);
  assign last_beat  = (lat_cnt == CNT_W'(MEM_LAT - 1));
  assign sp_inc     = sp + 1'b1;

  // Outputs decode straight from state so an async reset clears them at once.
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en && cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign if_valid  = (state_q == RESP) &&  cmd_q.is_if;
  assign dm_valid  = (state_q == RESP) && !cmd_q.is_if;
  assign if_stall  = if_req && !if_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (if_req || dm_req) state_d = ACCESS;
      ACCESS:  if (last_beat)        state_d = RESP;
      RESP:                          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q    <= '0;
      lat_cnt  <= '0;
      sp       <= SP_INIT;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          lat_cnt <= '0;
          if (if_win) begin
            cmd_q <= '{is_if: 1'b1, we: 1'b0, addr: if_addr, wdata: '0};
          end else if (dm_req) begin
            if (dm_push) begin
              cmd_q <= '{is_if: 1'b0, we: 1'b1, addr: sp, wdata: dm_wdata};
              sp    <= sp - 1'b1;
            end else if (dm_pop) begin
              cmd_q <= '{is_if: 1'b0, we: 1'b0, addr: sp_inc, wdata: dm_wdata};
              sp    <= sp_inc;
            end else begin
              cmd_q <= '{is_if: 1'b0, we: dm_we, addr: dm_addr, wdata: dm_wdata};
            end
          end
        end
        ACCESS: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (last_beat) begin
            if (cmd_q.is_if) if_rdata <= mem_rdata;
            else             dm_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Counts data grants taken while fetch waits; any gap in if_req forgives the history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (!if_req) begin
      burst_cnt <= '0;
    end else if (state_q == IDLE) begin
      if (if_win)                      burst_cnt <= '0;
      else if (dm_req && !burst_full)  burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule
